// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match FSM that owns scoring, the serve delay, the freeze and game over.
module pong_match_ctrl #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int WIN_BY_TWO  = 0,
    parameter int SERVE_TICKS = 60,
    parameter int RALLY_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               hit_left,
    input  logic               hit_right,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [RALLY_W-1:0] rally,
    output logic               gra_still,
    output logic               serve_dir,
    output logic               point,
    output logic               game_over,
    output logic               winner,
    output logic [1:0]         state
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_SERVE = 2'b01, S_PLAY = 2'b10, S_OVER = 2'b11} state_t;
    localparam int CNT_W = $clog2(SERVE_TICKS + 1);
    localparam logic [CNT_W-1:0]   TICKS = CNT_W'(SERVE_TICKS);
    localparam logic [SCORE_W-1:0] S_MAX = '1;
    localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [RALLY_W-1:0] R_MAX = '1;

    state_t             r_state, w_state;
    logic [SCORE_W-1:0] r_sl, r_sr, w_sl, w_sr;
    logic [RALLY_W-1:0] r_rally, w_rally;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_dir, w_dir, r_point, w_point, r_winner, w_winner;
    logic [SCORE_W-1:0] w_s, w_o, w_s_inc;
    logic               w_win;

    always_comb begin
        // scorer is the side opposite the miss; saturation at the cap always wins
        w_s     = miss_left ? r_sr : r_sl;
        w_o     = miss_left ? r_sl : r_sr;
        w_s_inc = (w_s == S_MAX) ? w_s : w_s + 1'b1;
        w_win   = (w_s_inc >= S_WIN && (WIN_BY_TWO == 0 ||
                   {1'b0, w_s_inc} >= {1'b0, w_o} + (SCORE_W+1)'(2))) || w_s_inc == S_MAX;
        w_state  = r_state;
        w_sl     = r_sl;
        w_sr     = r_sr;
        w_rally  = r_rally;
        w_cnt    = r_cnt;
        w_dir    = r_dir;
        w_point  = 1'b0;
        w_winner = r_winner;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start_btn) begin
                    w_state = S_SERVE;
                    w_sl    = '0;
                    w_sr    = '0;
                    w_rally = '0;
                    w_cnt   = TICKS;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    w_cnt   = r_cnt - 1'b1;
                    w_state = (r_cnt == CNT_W'(1)) ? S_PLAY : S_SERVE;
                end
            end
            S_PLAY: begin
                if (miss_left && miss_right) begin
                    w_state = S_SERVE;
                    w_cnt   = TICKS;
                    w_rally = '0;
                end else if (miss_left || miss_right) begin
                    w_rally = '0;
                    w_point = 1'b1;
                    w_dir   = miss_right;
                    w_sr    = miss_left ? w_s_inc : r_sr;
                    w_sl    = miss_right ? w_s_inc : r_sl;
                    w_state = w_win ? S_OVER : S_SERVE;
                    w_cnt   = w_win ? r_cnt : TICKS;
                    w_winner = w_win ? miss_left : r_winner;
                end else if (hit_left || hit_right) begin
                    w_rally = (r_rally == R_MAX) ? r_rally : r_rally + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sl     <= '0;
            r_sr     <= '0;
            r_rally  <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b1;
            r_point  <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sl     <= w_sl;
            r_sr     <= w_sr;
            r_rally  <= w_rally;
            r_cnt    <= w_cnt;
            r_dir    <= w_dir;
            r_point  <= w_point;
            r_winner <= w_winner;
        end
    end

    assign score_left  = r_sl;
    assign score_right = r_sr;
    assign rally       = r_rally;
    assign serve_dir   = r_dir;
    assign point       = r_point;
    assign winner      = r_winner;
    assign state       = r_state;
    assign gra_still   = r_state != S_PLAY;
    assign game_over   = r_state == S_OVER;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed and randomized checks of two match controllers against a score model.
module tb_pong_match_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic       ft[2], sb[2], hl[2], hr[2], ml[2], mr[2];
    logic [3:0] sl[2], sr[2];
    logic [7:0] ra[2];
    logic       gs[2], sd[2], pt[2], go[2], wn[2];
    logic [1:0] st[2];
    int checks = 0, errors = 0;

    localparam logic [5:0] SB = 6'b100000, FT = 6'b010000, HL = 6'b001000;
    localparam logic [5:0] HR = 6'b000100, ML = 6'b000010, MR = 6'b000001;
    localparam logic [22:0] RST_VAL = {2'b00, 4'd0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    pong_match_ctrl d0 (
        .clk(clk), .reset(reset), .frame_tick(ft[0]), .start_btn(sb[0]),
        .hit_left(hl[0]), .hit_right(hr[0]), .miss_left(ml[0]), .miss_right(mr[0]),
        .score_left(sl[0]), .score_right(sr[0]), .rally(ra[0]), .gra_still(gs[0]),
        .serve_dir(sd[0]), .point(pt[0]), .game_over(go[0]), .winner(wn[0]), .state(st[0])
    );

    pong_match_ctrl #(.WIN_BY_TWO(1), .SERVE_TICKS(3)) d1 (
        .clk(clk), .reset(reset), .frame_tick(ft[1]), .start_btn(sb[1]),
        .hit_left(hl[1]), .hit_right(hr[1]), .miss_left(ml[1]), .miss_right(mr[1]),
        .score_left(sl[1]), .score_right(sr[1]), .rally(ra[1]), .gra_still(gs[1]),
        .serve_dir(sd[1]), .point(pt[1]), .game_over(go[1]), .winner(wn[1]), .state(st[1])
    );

    // match model: st 0 idle, 1 serve, 2 play, 3 over; scores as plain integers
    typedef struct {int st, sl, sr, ra, cnt, dir, pt, wn;} mdl_t;
    mdl_t m[2];
    int   ticks[2] = '{60, 3};
    bit   by2[2]   = '{1'b0, 1'b1};

    function automatic mdl_t rst_m();
        mdl_t r;
        r = '{0, 0, 0, 0, 0, 1, 0, 0};
        return r;
    endfunction

    function automatic mdl_t nxt(mdl_t c, int k, logic [5:0] v);
        mdl_t n;
        int   s, o;
        bit   won;
        n = c;
        n.pt = 0;
        if ((c.st == 0 || c.st == 3) && v[5]) begin
            n.st = 1; n.sl = 0; n.sr = 0; n.ra = 0; n.cnt = ticks[k];
        end else if (c.st == 1 && v[4]) begin
            n.cnt = c.cnt - 1;
            if (n.cnt == 0) n.st = 2;
        end else if (c.st == 2) begin
            if (v[1] && v[0]) begin
                n.st = 1; n.cnt = ticks[k]; n.ra = 0;
            end else if (v[1] || v[0]) begin
                s = v[1] ? c.sr : c.sl;
                o = v[1] ? c.sl : c.sr;
                s = (s < 15) ? s + 1 : 15;
                won = (s >= 9 && (!by2[k] || s - o >= 2)) || s == 15;
                if (v[1]) n.sr = s; else n.sl = s;
                n.pt = 1; n.dir = int'(v[0]); n.ra = 0;
                if (won) begin n.st = 3; n.wn = int'(v[1]); end
                else begin n.st = 1; n.cnt = ticks[k]; end
            end else if (v[3] || v[2]) begin
                n.ra = (c.ra < 255) ? c.ra + 1 : 255;
            end
        end
        return n;
    endfunction

    function automatic logic [22:0] exp_of(mdl_t c);
        return {2'(c.st), 4'(c.sl), 4'(c.sr), 8'(c.ra), c.st != 2, 1'(c.dir), 1'(c.pt), c.st == 3, 1'(c.wn)};
    endfunction

    function automatic logic [22:0] act(int k);
        return {st[k], sl[k], sr[k], ra[k], gs[k], sd[k], pt[k], go[k], wn[k]};
    endfunction

    task automatic cyc(logic [5:0] v0, logic [5:0] v1);
        {sb[0], ft[0], hl[0], hr[0], ml[0], mr[0]} = v0;
        {sb[1], ft[1], hl[1], hr[1], ml[1], mr[1]} = v1;
        @(posedge clk);
        m[0] = nxt(m[0], 0, v0);
        m[1] = nxt(m[1], 1, v1);
        #1;
        {sb[0], ft[0], hl[0], hr[0], ml[0], mr[0]} = '0;
        {sb[1], ft[1], hl[1], hr[1], ml[1], mr[1]} = '0;
    endtask

    task automatic serve(int k);
        for (int i = 0; i < 300 && st[k] != 2'b10; i++) begin
            if (k == 0) cyc(FT, 0); else cyc(0, FT);
        end
        checks++;
        if (st[k] !== 2'b10) begin errors++; $display("FAIL serve_timeout dut%0d state=%b want=10", k, st[k]); end
    endtask

    task automatic pnt(int k, bit left);
        serve(k);
        if (k == 0) cyc(left ? MR : ML, 0); else cyc(0, left ? MR : ML);
    endtask

    task automatic test_reset();
        m[0] = rst_m(); m[1] = rst_m();
        #12;
        checks++; if (act(0) !== RST_VAL) begin errors++; $display("FAIL reset_d0 got=%h want=%h", act(0), RST_VAL); end
        checks++; if (act(1) !== RST_VAL) begin errors++; $display("FAIL reset_d1 got=%h want=%h", act(1), RST_VAL); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_start();
        cyc(SB | FT, 0);
        checks++; if (st[0] !== 2'b01 || gs[0] !== 1'b1) begin errors++; $display("FAIL start state=%b still=%b want=01/1", st[0], gs[0]); end
        checks++; if (sl[0] !== 4'd0 || sr[0] !== 4'd0) begin errors++; $display("FAIL start_scores got=%0d-%0d want=0-0", sl[0], sr[0]); end
        for (int i = 0; i < 59; i++) begin cyc(FT, 0); cyc(0, 0); end
        checks++; if (st[0] !== 2'b01) begin errors++; $display("FAIL tick59 state=%b want=01", st[0]); end
        cyc(FT, 0);
        checks++; if (st[0] !== 2'b10 || gs[0] !== 1'b0) begin errors++; $display("FAIL tick60 state=%b still=%b want=10/0", st[0], gs[0]); end
    endtask

    task automatic test_scoring();
        cyc(HL, 0); cyc(HL | HR, 0); cyc(HR, 0);
        checks++; if (ra[0] !== 8'd3) begin errors++; $display("FAIL rally got=%0d want=3", ra[0]); end
        cyc(MR, 0);
        checks++; if (sl[0] !== 4'd1 || pt[0] !== 1'b1 || sd[0] !== 1'b1) begin errors++; $display("FAIL point sl=%0d pt=%b dir=%b want=1/1/1", sl[0], pt[0], sd[0]); end
        checks++; if (ra[0] !== 8'd0 || st[0] !== 2'b01) begin errors++; $display("FAIL point_state rally=%0d state=%b want=0/01", ra[0], st[0]); end
        cyc(0, 0);
        checks++; if (pt[0] !== 1'b0) begin errors++; $display("FAIL point_pulse got=%b want=0", pt[0]); end
        cyc(ML, 0);
        checks++; if (sr[0] !== 4'd0 || st[0] !== 2'b01) begin errors++; $display("FAIL serve_miss sr=%0d state=%b want=0/01", sr[0], st[0]); end
    endtask

    task automatic test_simul();
        serve(0);
        cyc(ML | MR, 0);
        checks++; if (sl[0] !== 4'd1 || sr[0] !== 4'd0 || pt[0] !== 1'b0 || st[0] !== 2'b01) begin
            errors++; $display("FAIL double_miss got=%0d-%0d pt=%b state=%b want=1-0/0/01", sl[0], sr[0], pt[0], st[0]); end
        serve(0);
        cyc(HL, 0); cyc(HL | ML, 0);
        checks++; if (sr[0] !== 4'd1 || ra[0] !== 8'd0 || sd[0] !== 1'b0) begin errors++; $display("FAIL hit_miss sr=%0d rally=%0d dir=%b want=1/0/0", sr[0], ra[0], sd[0]); end
        for (int i = 0; i < 59; i++) cyc(FT, 0);
        cyc(FT | ML, 0);
        checks++; if (st[0] !== 2'b10 || sr[0] !== 4'd1) begin errors++; $display("FAIL edge_miss state=%b sr=%0d want=10/1", st[0], sr[0]); end
    endtask

    task automatic test_win();
        for (int i = 0; i < 8; i++) pnt(0, 1'b1);
        checks++; if (st[0] !== 2'b11 || go[0] !== 1'b1 || wn[0] !== 1'b0 || gs[0] !== 1'b1) begin
            errors++; $display("FAIL win state=%b over=%b winner=%b still=%b want=11/1/0/1", st[0], go[0], wn[0], gs[0]); end
        checks++; if (sl[0] !== 4'd9) begin errors++; $display("FAIL win_score got=%0d want=9", sl[0]); end
        cyc(ML, 0); cyc(FT, 0);
        checks++; if (sr[0] !== 4'd1 || st[0] !== 2'b11) begin errors++; $display("FAIL over_frozen sr=%0d state=%b want=1/11", sr[0], st[0]); end
        cyc(SB, 0);
        checks++; if (sl[0] !== 4'd0 || sr[0] !== 4'd0 || st[0] !== 2'b01 || go[0] !== 1'b0) begin
            errors++; $display("FAIL restart got=%0d-%0d state=%b over=%b want=0-0/01/0", sl[0], sr[0], st[0], go[0]); end
    endtask

    task automatic test_win_by_two();
        cyc(0, SB);
        for (int i = 0; i < 8; i++) begin pnt(1, 1'b1); pnt(1, 1'b0); end
        pnt(1, 1'b1);
        checks++; if (st[1] !== 2'b01 || sl[1] !== 4'd9) begin errors++; $display("FAIL wb2_9_8 state=%b sl=%0d want=01/9", st[1], sl[1]); end
        pnt(1, 1'b1);
        checks++; if (st[1] !== 2'b11 || wn[1] !== 1'b0) begin errors++; $display("FAIL wb2_10_8 state=%b winner=%b want=11/0", st[1], wn[1]); end
        cyc(0, SB);
        for (int i = 0; i < 8; i++) begin pnt(1, 1'b1); pnt(1, 1'b0); end
        pnt(1, 1'b0);
        checks++; if (st[1] !== 2'b01) begin errors++; $display("FAIL wb2_8_9 state=%b want=01", st[1]); end
        pnt(1, 1'b1);
        checks++; if (st[1] !== 2'b01 || sl[1] !== 4'd9 || sr[1] !== 4'd9) begin errors++; $display("FAIL wb2_9_9 state=%b got=%0d-%0d want=01/9-9", st[1], sl[1], sr[1]); end
        for (int i = 0; i < 5; i++) begin pnt(1, 1'b0); pnt(1, 1'b1); end
        checks++; if (st[1] !== 2'b01 || sl[1] !== 4'd14 || sr[1] !== 4'd14) begin errors++; $display("FAIL wb2_14_14 state=%b got=%0d-%0d want=01/14-14", st[1], sl[1], sr[1]); end
        pnt(1, 1'b0);
        checks++; if (st[1] !== 2'b11 || wn[1] !== 1'b1 || sr[1] !== 4'd15) begin errors++; $display("FAIL wb2_cap state=%b winner=%b sr=%0d want=11/1/15", st[1], wn[1], sr[1]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(FT, 0);
        checks++; if (st[0] !== 2'b01) begin errors++; $display("FAIL pre_reset state=%b want=01", st[0]); end
        @(negedge clk); #2 reset = 1'b1; #1;
        m[0] = rst_m(); m[1] = rst_m();
        checks++; if (act(0) !== RST_VAL) begin errors++; $display("FAIL async_reset_d0 got=%h want=%h", act(0), RST_VAL); end
        checks++; if (act(1) !== RST_VAL) begin errors++; $display("FAIL async_reset_d1 got=%h want=%h", act(1), RST_VAL); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] v[2];
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 2; k++)
                v[k] = {$urandom_range(15) == 0, $urandom_range(1) == 0, $urandom_range(3) == 0,
                        $urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0};
            cyc(v[0], v[1]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act(k) !== exp_of(m[k])) begin
                    errors++; $display("FAIL rand dut%0d cyc%0d got=%h want=%h", k, n, act(k), exp_of(m[k]));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) {sb[k], ft[k], hl[k], hr[k], ml[k], mr[k]} = '0;
        test_reset();
        test_start();
        test_scoring();
        test_simul();
        test_win();
        test_win_by_two();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the Pong game. It owns scoring, the serve delay, the freeze (`gra_still`) and game-over state for both players, and replaces the earlier fixed freeze-on-game-over logic. It sits between the graphics engine (`hit`/`miss` per side) and the score/font display, and is paced by the once-per-frame refresh tick.

## Interface

Parameters:
- `SCORE_W`, default 4: width of each score register.
- `WIN_SCORE`, default 9: points needed to win. Legal range 1 .. 2^SCORE_W-1.
- `WIN_BY_TWO`, default 0: when 1, the winner also needs a lead of at least 2.
- `SERVE_TICKS`, default 60: frames of freeze before each serve. Must be at least 1.
- `RALLY_W`, default 8: width of the rally hit counter.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: synchronous one-cycle start pulse (debounced upstream).
- `hit_left`, `hit_right` in 1: ball-paddle contact pulses.
- `miss_left` in 1: ball passed the left paddle, so right scores.
- `miss_right` in 1: ball passed the right paddle, so left scores.
- `score_left`, `score_right` out SCORE_W: current scores.
- `rally` out RALLY_W: paddle hits in the current rally.
- `gra_still` out 1: freeze ball and paddles.
- `serve_dir` out 1: 0 means serve toward left, 1 means serve toward right.
- `point` out 1: one-cycle pulse when a point is awarded.
- `game_over` out 1: match finished.
- `winner` out 1: 0 means left, 1 means right. Valid while `game_over` is high.
- `state` out 2: IDLE=00, SERVE=01, PLAY=10, OVER=11.

## Operation

- Reset values: state IDLE, both scores 0, rally 0, `gra_still` 1, `serve_dir` 1, `point` 0, `game_over` 0, `winner` 0. The serve counter is also 0.
- **IDLE:** `gra_still` is 1. On `start_btn` go to SERVE, clear both scores and rally, and load the serve counter with SERVE_TICKS.
- **SERVE:** `gra_still` is 1.
  - Each `frame_tick` decrements the counter.
  - A `frame_tick` while the counter is 1 moves to PLAY.
  - Hit and miss inputs are ignored.
- **PLAY:** `gra_still` is 0.
  - Each `hit_left` or `hit_right` increments `rally`, saturating at 2^RALLY_W-1. Simultaneous hits count as +1.
  - `miss_left` alone: `score_right` +1, `point` pulses, `serve_dir` becomes 0 (serve toward the player who conceded).
  - `miss_right` alone: `score_left` +1, `point` pulses, `serve_dir` becomes 1.
  - `miss_left` and `miss_right` together: no score and no `point`, `serve_dir` unchanged, go to SERVE (replayed point).
  - After a point, evaluate the win test on the new scores. On a win go to OVER; otherwise go to SERVE, reload the counter and clear rally.
  - Misses take priority over hits in the same cycle; rally is cleared.
- **Win test** for scorer S with new score s and opponent score o. The match is won if either:
  - s ≥ WIN_SCORE and (WIN_BY_TWO==0 or s−o ≥ 2), or
  - s == 2^SCORE_W−1 (saturation cap: the scorer wins regardless of lead).
- Scores never wrap.
- **OVER:** `gra_still` is 1, `game_over` is 1, `winner` is held. Scores and rally are frozen. On `start_btn` go to SERVE with scores cleared, rally cleared, `game_over` cleared and the counter reloaded.
- `start_btn` is ignored in SERVE and PLAY.
- `frame_tick` is ignored outside SERVE.
- Asserting reset in any state returns every output to its reset value immediately, without waiting for a clock edge.

## Timing

- All outputs are registered. Every update becomes visible the cycle after the causing input edge.
- Point latency: a miss in cycle N gives updated score, `point`=1 and the new state in cycle N+1. `point` is low in N+2.
- Serve delay: PLAY is entered the cycle after the SERVE_TICKS-th `frame_tick` counted in SERVE.
  - A `frame_tick` coinciding with the cycle SERVE is entered is not counted.
- `gra_still` and `game_over` are decoded from registered state, so they switch in the same cycle as `state`.
- A miss pulse that arrives in the same cycle as the SERVE→PLAY transition is ignored.

## Test plan

- **Reset and start:** reset, then `start_btn` → `state` 01, scores 0, `gra_still` 1. After 60 `frame_tick`s → `state` 10, `gra_still` 0 one cycle after the 60th tick.
- **Basic scoring (WIN_SCORE=9, WIN_BY_TWO=0):** 3 hits then `miss_right` → `rally` reaches 3, then `score_left` 1, `point` pulses for one cycle, `serve_dir` 1, `rally` 0, `state` 01.
- **Win:** drive the left score to 9 → `state` 11, `game_over` 1, `winner` 0. A further `miss_left` leaves `score_right` unchanged. `start_btn` → scores 0, `state` 01.
- **Win-by-two (WIN_BY_TWO=1, SCORE_W=4):**
  - From 9–8, a left point gives 10–8 → OVER.
  - From 8–9, a left point gives 9–9 → SERVE.
  - From 14–14, the next point gives 15 → OVER via the cap.
- **Simultaneous events:** `miss_left` and `miss_right` in the same PLAY cycle → scores unchanged, no `point`, `state` 01. `hit_left` and `miss_left` together → `score_right` +1, `rally` 0.
- **Asynchronous reset mid-SERVE with partial count:** all outputs return to reset values without a clock edge, and `state` is 00.
